// File: rtl/retire_checker.sv
// In-order retirement scoreboard: queues expected retire records, compares each DUT retirement against the head.
// Latency: compare result, counters and error capture are registered (visible the cycle after the popping edge).
// Backpressure: exp_ready drops while the queue holds DEPTH records; a push offered while full is dropped.
// Optional feature macro: RETIRE_CHECKER_XPROP_EN (X/Z wildcards in expected fields, XDUT detection on DUT fields).
module retire_checker #(
    parameter int PC_W    = 16,
    parameter int DATA_W  = 16,
    parameter int FLAG_W  = 3,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     exp_valid,
    output logic                     exp_ready,
    input  logic [PC_W-1:0]          exp_pc,
    input  logic [DATA_W-1:0]        exp_data,
    input  logic [FLAG_W-1:0]        exp_flags,
    input  logic                     dut_valid,
    input  logic [PC_W-1:0]          dut_pc,
    input  logic [DATA_W-1:0]        dut_data,
    input  logic [FLAG_W-1:0]        dut_flags,
    input  logic                     clr_err,
    output logic                     err,
    output logic [2:0]               err_code,
    output logic [PC_W-1:0]          err_pc,
    output logic [$clog2(DEPTH):0]   pending,
    output logic [CNT_W-1:0]         match_cnt,
    output logic [CNT_W-1:0]         mism_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int WD_W  = $clog2(TIMEOUT) + 1;

    localparam logic [PTR_W:0]  FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Error cause encodings
    localparam logic [2:0] CODE_NONE  = 3'd0;
    localparam logic [2:0] CODE_PC    = 3'd1;
    localparam logic [2:0] CODE_DATA  = 3'd2;
    localparam logic [2:0] CODE_FLAGS = 3'd3;
    localparam logic [2:0] CODE_UFLOW = 3'd4;
    localparam logic [2:0] CODE_TOUT  = 3'd5;
`ifdef RETIRE_CHECKER_XPROP_EN
    localparam logic [2:0] CODE_XDUT  = 3'd6;
`endif

    // Expected-record storage (no reset needed: occupancy tracks validity)
    logic [PC_W-1:0]   r_q_pc    [DEPTH];
    logic [DATA_W-1:0] r_q_data  [DEPTH];
    logic [FLAG_W-1:0] r_q_flags [DEPTH];

    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_pending;
    logic [WD_W-1:0]   r_wdog;
    logic              r_err;
    logic [2:0]        r_err_code;
    logic [PC_W-1:0]   r_err_pc;
    logic [CNT_W-1:0]  r_match_cnt;
    logic [CNT_W-1:0]  r_mism_cnt;

    logic              w_empty;
    logic              w_ready;
    logic              w_push;
    logic              w_pop_dut;
    logic              w_underflow;
    logic              w_timeout;
    logic              w_pop;
    logic [PC_W-1:0]   w_head_pc;
    logic [DATA_W-1:0] w_head_data;
    logic [FLAG_W-1:0] w_head_flags;
    logic [2:0]        w_cmp_code;
    logic              w_new_err;
    logic [2:0]        w_new_code;
    logic [PC_W-1:0]   w_new_pc;
    logic              w_inc_match;
    logic              w_inc_mism;

    assign w_empty      = (r_pending == '0);
    assign w_ready      = (r_pending != FULL_CNT);
    assign w_push       = exp_valid && w_ready;
    assign w_pop_dut    = dut_valid && !w_empty;
    // No bypass: a retirement against an empty queue is an underflow even if a push lands this cycle
    assign w_underflow  = dut_valid && w_empty;
    assign w_timeout    = !w_empty && !dut_valid && (r_wdog == WD_LAST);
    assign w_pop        = w_pop_dut || w_timeout;

    assign w_head_pc    = r_q_pc[r_rd_ptr];
    assign w_head_data  = r_q_data[r_rd_ptr];
    assign w_head_flags = r_q_flags[r_rd_ptr];

    // Field compare against the head; first failing field in PC, DATA, FLAGS order wins
    always_comb begin
        w_cmp_code = CODE_NONE;
`ifdef RETIRE_CHECKER_XPROP_EN
        if ($isunknown({dut_pc, dut_data, dut_flags})) begin
            w_cmp_code = CODE_XDUT;
        end else if (!(dut_pc ==? w_head_pc)) begin
            w_cmp_code = CODE_PC;
        end else if (!(dut_data ==? w_head_data)) begin
            w_cmp_code = CODE_DATA;
        end else if (!(dut_flags ==? w_head_flags)) begin
            w_cmp_code = CODE_FLAGS;
        end
`else
        if (dut_pc !== w_head_pc) begin
            w_cmp_code = CODE_PC;
        end else if (dut_data !== w_head_data) begin
            w_cmp_code = CODE_DATA;
        end else if (dut_flags !== w_head_flags) begin
            w_cmp_code = CODE_FLAGS;
        end
`endif
    end

    // Select the error (if any) produced on this edge and the counter that moves
    always_comb begin
        w_new_err   = 1'b0;
        w_new_code  = CODE_NONE;
        w_new_pc    = '0;
        w_inc_match = 1'b0;
        w_inc_mism  = 1'b0;
        if (w_underflow) begin
            w_new_err  = 1'b1;
            w_new_code = CODE_UFLOW;
            w_new_pc   = dut_pc;
        end else if (w_pop_dut) begin
            if (w_cmp_code == CODE_NONE) begin
                w_inc_match = 1'b1;
            end else begin
                w_inc_mism = 1'b1;
                w_new_err  = 1'b1;
                w_new_code = w_cmp_code;
                w_new_pc   = w_head_pc;
            end
        end else if (w_timeout) begin
            w_inc_mism = 1'b1;
            w_new_err  = 1'b1;
            w_new_code = CODE_TOUT;
            w_new_pc   = w_head_pc;
        end
    end

    // Write accepted expected records into the queue storage
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q_pc[r_wr_ptr]    <= exp_pc;
            r_q_data[r_wr_ptr]  <= exp_data;
            r_q_flags[r_wr_ptr] <= exp_flags;
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_pending <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_pending <= r_pending + 1'b1;
                2'b01:   r_pending <= r_pending - 1'b1;
                default: r_pending <= r_pending;
            endcase
        end
    end

    // Retirement-stall watchdog: counts idle cycles while records are outstanding
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= '0;
        end else if (w_empty || dut_valid || w_timeout) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    // Saturating match / mismatch counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_match_cnt <= '0;
            r_mism_cnt  <= '0;
        end else begin
            if (w_inc_match && (r_match_cnt != CNT_MAX)) begin
                r_match_cnt <= r_match_cnt + 1'b1;
            end
            if (w_inc_mism && (r_mism_cnt != CNT_MAX)) begin
                r_mism_cnt <= r_mism_cnt + 1'b1;
            end
        end
    end

    // Sticky first-error capture; clear wins over a capture on the same edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err      <= 1'b0;
            r_err_code <= CODE_NONE;
            r_err_pc   <= '0;
        end else if (clr_err) begin
            r_err      <= 1'b0;
            r_err_code <= CODE_NONE;
            r_err_pc   <= '0;
        end else if (!r_err && w_new_err) begin
            r_err      <= 1'b1;
            r_err_code <= w_new_code;
            r_err_pc   <= w_new_pc;
        end
    end

    assign exp_ready = w_ready;
    assign err       = r_err;
    assign err_code  = r_err_code;
    assign err_pc    = r_err_pc;
    assign pending   = r_pending;
    assign match_cnt = r_match_cnt;
    assign mism_cnt  = r_mism_cnt;

endmodule

// File: tb/tb_retire_checker.sv
// Bench for retire_checker: directed vector table, multi-cycle corner sequences, randomized run against a queue model.
// Latency: outputs checked 1 time unit after each rising edge.
// Backpressure: the model predicts exp_ready from its own queue size.
module tb_retire_checker;

    logic        clk;
    logic        rst_n;
    logic        exp_valid;
    logic        exp_ready;
    logic [15:0] exp_pc;
    logic [15:0] exp_data;
    logic [2:0]  exp_flags;
    logic        dut_valid;
    logic [15:0] dut_pc;
    logic [15:0] dut_data;
    logic [2:0]  dut_flags;
    logic        clr_err;
    logic        err;
    logic [2:0]  err_code;
    logic [15:0] err_pc;
    logic [3:0]  pending;
    logic [15:0] match_cnt;
    logic [15:0] mism_cnt;

    int tests = 0;
    int fails = 0;

    retire_checker dut_i (
        .clk       (clk),
        .rst_n     (rst_n),
        .exp_valid (exp_valid),
        .exp_ready (exp_ready),
        .exp_pc    (exp_pc),
        .exp_data  (exp_data),
        .exp_flags (exp_flags),
        .dut_valid (dut_valid),
        .dut_pc    (dut_pc),
        .dut_data  (dut_data),
        .dut_flags (dut_flags),
        .clr_err   (clr_err),
        .err       (err),
        .err_code  (err_code),
        .err_pc    (err_pc),
        .pending   (pending),
        .match_cnt (match_cnt),
        .mism_cnt  (mism_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ev;
        logic [15:0] epc;
        logic [15:0] edat;
        logic [2:0]  efl;
        logic        dv;
        logic [15:0] dpc;
        logic [15:0] ddat;
        logic [2:0]  dfl;
        logic        clr;
        logic        x_err;
        logic [2:0]  x_code;
        logic [15:0] x_epc;
        int          x_pend;
        int          x_match;
        int          x_mism;
    } vec_t;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] data;
        logic [2:0]  fl;
    } rec_t;

    vec_t tbl [20];

    // Reference model state
    rec_t        mq[$];
    logic        m_err;
    logic [2:0]  m_code;
    logic [15:0] m_epc;
    int          m_match;
    int          m_mism;
    int          m_idle;

    task automatic check_state(input string nm, input logic xe, input logic [2:0] xc, input logic [15:0] xp,
                               input int xpend, input int xm, input int xmm);
        logic xr;
        xr = (xpend != 8);
        tests++;
        if (err !== xe || err_code !== xc || err_pc !== xp || pending !== 4'(xpend) ||
            match_cnt !== 16'(xm) || mism_cnt !== 16'(xmm) || exp_ready !== xr) begin
            fails++;
            $display("FAIL %s: got err=%0b code=%0d pc=%h pend=%0d match=%0d mism=%0d rdy=%0b; want err=%0b code=%0d pc=%h pend=%0d match=%0d mism=%0d rdy=%0b",
                     nm, err, err_code, err_pc, pending, match_cnt, mism_cnt, exp_ready,
                     xe, xc, xp, xpend, xm, xmm, xr);
        end
    endtask

    task automatic drive(input logic ev, input logic [15:0] epc, input logic [15:0] edat, input logic [2:0] efl,
                         input logic dv, input logic [15:0] dpc, input logic [15:0] ddat, input logic [2:0] dfl,
                         input logic clr);
        exp_valid = ev;  exp_pc = epc;  exp_data = edat;  exp_flags = efl;
        dut_valid = dv;  dut_pc = dpc;  dut_data = ddat;  dut_flags = dfl;
        clr_err   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
    endtask

    task automatic do_reset();
        exp_valid = 1'b0; dut_valid = 1'b0; clr_err = 1'b0;
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        mq.delete();
        m_err = 1'b0; m_code = 3'd0; m_epc = 16'h0;
        m_match = 0; m_mism = 0; m_idle = 0;
    endtask

    // Predicts the outcome of the coming edge from the rules: compare against queue head, watchdog, first-error capture
    task automatic model_step();
        rec_t        h;
        int          sz;
        logic        rdy;
        logic        to;
        logic [2:0]  c;
        logic [15:0] cp;
        sz  = mq.size();
        rdy = (sz != 8);
        to  = 1'b0;
        c   = 3'd0;
        cp  = 16'h0;
        if (dut_valid && sz == 0) begin
            c  = 3'd4;
            cp = dut_pc;
        end else if (dut_valid) begin
            h = mq.pop_front();
            if (dut_pc != h.pc) c = 3'd1;
            else if (dut_data != h.data) c = 3'd2;
            else if (dut_flags != h.fl) c = 3'd3;
            if (c == 3'd0) begin
                if (m_match < 65535) m_match++;
            end else begin
                if (m_mism < 65535) m_mism++;
            end
            cp = h.pc;
        end else if (sz != 0 && m_idle == 63) begin
            h  = mq.pop_front();
            c  = 3'd5;
            cp = h.pc;
            to = 1'b1;
            if (m_mism < 65535) m_mism++;
        end
        if (exp_valid && rdy) mq.push_back('{exp_pc, exp_data, exp_flags});
        if (sz == 0 || dut_valid || to) m_idle = 0;
        else m_idle++;
        if (clr_err) begin
            m_err = 1'b0; m_code = 3'd0; m_epc = 16'h0;
        end else if (!m_err && c != 3'd0) begin
            m_err = 1'b1; m_code = c; m_epc = cp;
        end
    endtask

    initial begin
        // {ev, epc, edat, efl, dv, dpc, ddat, dfl, clr, x_err, x_code, x_epc, x_pend, x_match, x_mism}
        tbl[0]  = '{1, 16'h0000, 16'h1111, 3'd0, 0, 16'h0000, 16'h0000, 3'd0, 0, 0, 3'd0, 16'h0000, 1, 0, 0};
        tbl[1]  = '{1, 16'h0002, 16'h2222, 3'd1, 1, 16'h0000, 16'h1111, 3'd0, 0, 0, 3'd0, 16'h0000, 1, 1, 0};
        tbl[2]  = '{1, 16'h0004, 16'h3333, 3'd2, 1, 16'h0002, 16'h2222, 3'd1, 0, 0, 3'd0, 16'h0000, 1, 2, 0};
        tbl[3]  = '{0, 16'h0000, 16'h0000, 3'd0, 1, 16'h0004, 16'h3333, 3'd2, 0, 0, 3'd0, 16'h0000, 0, 3, 0};
        tbl[4]  = '{1, 16'h0010, 16'h1234, 3'b010, 0, 16'h0000, 16'h0000, 3'd0, 0, 0, 3'd0, 16'h0000, 1, 3, 0};
        tbl[5]  = '{0, 16'h0000, 16'h0000, 3'd0, 1, 16'h0010, 16'h1235, 3'b011, 0, 1, 3'd2, 16'h0010, 0, 3, 1};
        tbl[6]  = '{1, 16'h0012, 16'h5555, 3'd0, 0, 16'h0000, 16'h0000, 3'd0, 0, 1, 3'd2, 16'h0010, 1, 3, 1};
        tbl[7]  = '{0, 16'h0000, 16'h0000, 3'd0, 1, 16'h0013, 16'h5555, 3'd0, 0, 1, 3'd2, 16'h0010, 0, 3, 2};
        tbl[8]  = '{0, 16'h0000, 16'h0000, 3'd0, 0, 16'h0000, 16'h0000, 3'd0, 1, 0, 3'd0, 16'h0000, 0, 3, 2};
        tbl[9]  = '{0, 16'h0000, 16'h0000, 3'd0, 1, 16'h00A0, 16'h0000, 3'd0, 0, 1, 3'd4, 16'h00A0, 0, 3, 2};
        tbl[10] = '{0, 16'h0000, 16'h0000, 3'd0, 0, 16'h0000, 16'h0000, 3'd0, 1, 0, 3'd0, 16'h0000, 0, 3, 2};
        tbl[11] = '{1, 16'h0020, 16'h0007, 3'd1, 1, 16'h0030, 16'h0000, 3'd0, 0, 1, 3'd4, 16'h0030, 1, 3, 2};
        tbl[12] = '{0, 16'h0000, 16'h0000, 3'd0, 1, 16'h0020, 16'h0007, 3'd0, 1, 0, 3'd0, 16'h0000, 0, 3, 3};
        tbl[13] = '{1, 16'h0040, 16'h0001, 3'd4, 0, 16'h0000, 16'h0000, 3'd0, 0, 0, 3'd0, 16'h0000, 1, 3, 3};
        tbl[14] = '{0, 16'h0000, 16'h0000, 3'd0, 1, 16'h0040, 16'h0001, 3'd4, 0, 0, 3'd0, 16'h0000, 0, 4, 3};
        tbl[15] = '{1, 16'h0050, 16'hAAAA, 3'd5, 0, 16'h0000, 16'h0000, 3'd0, 0, 0, 3'd0, 16'h0000, 1, 4, 3};
        tbl[16] = '{0, 16'h0000, 16'h0000, 3'd0, 1, 16'h0050, 16'hAAAA, 3'd4, 0, 1, 3'd3, 16'h0050, 0, 4, 4};
        tbl[17] = '{0, 16'h0000, 16'h0000, 3'd0, 0, 16'h0000, 16'h0000, 3'd0, 1, 0, 3'd0, 16'h0000, 0, 4, 4};
        tbl[18] = '{1, 16'h0060, 16'h0001, 3'd1, 0, 16'h0000, 16'h0000, 3'd0, 0, 0, 3'd0, 16'h0000, 1, 4, 4};
        tbl[19] = '{0, 16'h0000, 16'h0000, 3'd0, 1, 16'h0061, 16'h0002, 3'd2, 0, 1, 3'd1, 16'h0060, 0, 4, 5};

        exp_pc = 16'h0; exp_data = 16'h0; exp_flags = 3'd0;
        dut_pc = 16'h0; dut_data = 16'h0; dut_flags = 3'd0;
        do_reset();
        #1;
        check_state("reset", 1'b0, 3'd0, 16'h0, 0, 0, 0);

        // Directed vector table
        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].ev, tbl[i].epc, tbl[i].edat, tbl[i].efl,
                  tbl[i].dv, tbl[i].dpc, tbl[i].ddat, tbl[i].dfl, tbl[i].clr);
            check_state($sformatf("vec%0d", i), tbl[i].x_err, tbl[i].x_code, tbl[i].x_epc,
                        tbl[i].x_pend, tbl[i].x_match, tbl[i].x_mism);
        end

        // Full queue: dropped push, pop+push while full, refill, drain in order
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(16'h0100 + 2 * i), 16'(i), 3'd0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
        end
        check_state("full", 1'b0, 3'd0, 16'h0, 8, 4, 5);
        drive(1'b1, 16'h0999, 16'h0999, 3'd7, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
        check_state("drop_when_full", 1'b0, 3'd0, 16'h0, 8, 4, 5);
        drive(1'b1, 16'h0200, 16'hBEEF, 3'd7, 1'b1, 16'h0100, 16'h0000, 3'd0, 1'b0);
        check_state("pop_push_full", 1'b0, 3'd0, 16'h0, 7, 5, 5);
        drive(1'b1, 16'h0200, 16'hBEEF, 3'd7, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
        check_state("refill", 1'b0, 3'd0, 16'h0, 8, 5, 5);
        for (int i = 1; i < 8; i++) begin
            drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b1, 16'(16'h0100 + 2 * i), 16'(i), 3'd0, 1'b0);
        end
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b1, 16'h0200, 16'hBEEF, 3'd7, 1'b0);
        check_state("drain_wrap", 1'b0, 3'd0, 16'h0, 0, 13, 5);

        // Watchdog: one record, 63 idle edges keep it, the 64th discards it
        drive(1'b1, 16'h0300, 16'h0001, 3'd1, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
        for (int k = 0; k < 63; k++) idle();
        check_state("wdog_63", 1'b0, 3'd0, 16'h0, 1, 13, 5);
        idle();
        check_state("wdog_64", 1'b1, 3'd5, 16'h0300, 0, 13, 6);

        // Reset mid-operation drops in-flight records with no error
        drive(1'b1, 16'h0400, 16'h0001, 3'd0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
        drive(1'b1, 16'h0402, 16'h0002, 3'd0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
        do_reset();
        #1;
        check_state("reset_midop", 1'b0, 3'd0, 16'h0, 0, 0, 0);
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b1, 16'h0400, 16'h0001, 3'd0, 1'b0);
        check_state("after_reset_uflow", 1'b1, 3'd4, 16'h0400, 0, 0, 0);

`ifdef RETIRE_CHECKER_XPROP_EN
        do_reset();
        drive(1'b1, 16'h0010, 16'h12xx, 3'd0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b1, 16'h0010, 16'h12FF, 3'd0, 1'b0);
        check_state("xprop_wild", 1'b0, 3'd0, 16'h0, 0, 1, 0);
        drive(1'b1, 16'h0012, 16'h0000, 3'd0, 1'b0, 16'h0, 16'h0, 3'd0, 1'b0);
        drive(1'b0, 16'h0, 16'h0, 3'd0, 1'b1, 16'h0012, 16'h0000, 3'b0x0, 1'b0);
        check_state("xprop_xdut", 1'b1, 3'd6, 16'h0012, 0, 1, 1);
`endif

        // Randomized run against the queue model; every third block starves retirements to hit the watchdog
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int   pdv;
            logic [1:0] sel;
            pdv = (((cyc / 300) % 3) == 2) ? 0 : 55;
            exp_valid = ($urandom_range(0, 99) < 50);
            exp_pc    = 16'($urandom);
            exp_data  = 16'($urandom);
            exp_flags = 3'($urandom);
            clr_err   = ($urandom_range(0, 99) < 3);
            dut_valid = ($urandom_range(0, 99) < pdv);
            if (mq.size() != 0) begin
                dut_pc = mq[0].pc; dut_data = mq[0].data; dut_flags = mq[0].fl;
                if ($urandom_range(0, 99) < 25) begin
                    sel = 2'($urandom_range(0, 2));
                    if (sel == 2'd0) dut_pc = dut_pc ^ 16'(1 << $urandom_range(0, 15));
                    else if (sel == 2'd1) dut_data = dut_data ^ 16'(1 << $urandom_range(0, 15));
                    else dut_flags = dut_flags ^ 3'(1 << $urandom_range(0, 2));
                end
            end else begin
                dut_pc = 16'($urandom); dut_data = 16'($urandom); dut_flags = 3'($urandom);
            end
            model_step();
            @(posedge clk);
            #1;
            check_state($sformatf("rand%0d", cyc), m_err, m_code, m_epc, mq.size(), m_match, m_mism);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/retire_checker.md
Name: retire_checker

Overview:
- Parametrised in-order retirement scoreboard for the pipelined WISC CPU bench. It replaces per-stage, single-shot compare tasks.
- The reference model pushes expected retirement records (PC, result, flags) into a DEPTH-entry queue.
- Each DUT retirement pops the head entry and compares against it. The block keeps a sticky first-error capture, match/mismatch counters and a retirement-stall watchdog.
- Sits beside the CPU top in the testbench, fed from the model and the writeback-stage probes.

Parameters:
- PC_W, 16, PC width.
- DATA_W, 16, result width.
- FLAG_W, 3, flag width (Z,V,N).
- DEPTH, 8, expected-queue entries; power of 2, at least 2.
- TIMEOUT, 64, maximum cycles with the queue non-empty and no DUT retirement; at least 2.
- CNT_W, 16, width of each counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- exp_valid  in  1  model presents an expected record
- exp_ready  out  1  queue can accept a record
- exp_pc  in  PC_W  expected PC
- exp_data  in  DATA_W  expected result
- exp_flags  in  FLAG_W  expected flags
- dut_valid  in  1  DUT retired an instruction this cycle
- dut_pc  in  PC_W  DUT PC
- dut_data  in  DATA_W  DUT result
- dut_flags  in  FLAG_W  DUT flags
- clr_err  in  1  clears err, err_code, err_pc
- err  out  1  sticky error
- err_code  out  3  first error cause
- err_pc  out  PC_W  expected PC of the first error (dut_pc for UNDERFLOW)
- pending  out  clog2(DEPTH)+1  queue occupancy
- match_cnt  out  CNT_W  clean retirements
- mism_cnt  out  CNT_W  failed retirements, including timeouts

Behaviour:
- Reset (asynchronous): queue empty, pending=0, err=0, err_code=0, err_pc=0, both counters 0, watchdog 0. exp_ready is 1 after reset.
- Push rule:
  - exp_ready = (pending != DEPTH).
  - A push happens on a clock edge with exp_valid && exp_ready.
  - A push while full is not performed; exp_valid is ignored that cycle.
- Pop rule: a pop happens on a clock edge with dut_valid && pending != 0. It compares against the head as it stood before that edge.
- No bypass: dut_valid with pending=0 is an UNDERFLOW, even if a push happens in the same cycle. The pushed record is still enqueued.
- Push and pop in the same cycle: pending is unchanged. Read and write pointers wrap modulo DEPTH.
- Compare priority (first field that fails wins): PC (code 1), DATA (2), FLAGS (3).
- Other codes: UNDERFLOW 4, TIMEOUT 5, XDUT 6, none 0.
- Outcome of a pop:
  - All fields equal: match_cnt increments.
  - Any field fails: mism_cnt increments.
- Counters saturate at all-ones.
- Error capture:
  - Results are registered; err, err_code and err_pc update on the edge that performs the pop, visible the following cycle.
  - Only the first error is captured; later errors change the counters only.
  - UNDERFLOW does not touch the counters.
- Watchdog:
  - Increments each cycle when pending != 0 and dut_valid = 0. Clears on any dut_valid or when pending = 0.
  - When it reaches TIMEOUT-1 and no retirement occurs on that edge: the head is discarded (pop), mism_cnt increments, the TIMEOUT error is captured, and the watchdog clears.
- clr_err: synchronous. It has priority over a new capture on the same edge, so that edge's error is lost. It does not clear the counters or the queue.
- Reset mid-operation: all in-flight records are dropped with no error reported.

Optional Feature:
- Macro: RETIRE_CHECKER_XPROP_EN.
- When defined:
  - X/Z bits in exp_* fields act as wildcards (wildcard-equality compare).
  - Any X/Z bit in dut_pc, dut_data or dut_flags on a pop reports XDUT (code 6), ahead of PC/DATA/FLAGS.
- When undefined: fields are compared with exact four-state case equality (!==), there are no wildcards, and code 6 never occurs.

Test Plan:
- Push PCs 0x0000, 0x0002, 0x0004 with matching DUT retirements one per cycle → match_cnt=3, mism_cnt=0, err=0, pending=0.
- Fill 8 entries → exp_ready=0. A 9th exp_valid is dropped. Next cycle, dut_valid (pop) and exp_valid together → pending stays 7, then refill to 8; the dropped record never appears.
- Expected {0x0010, 0x1234, 3'b010}, DUT {0x0010, 0x1235, 3'b011} → err=1, err_code=2 (DATA beats FLAGS), err_pc=0x0010, mism_cnt=1. A second mismatch leaves err_code at 2.
- dut_valid with pending=0 and dut_pc=0x00A0 → err_code=4, err_pc=0x00A0, counters unchanged. Then clr_err → err=0, err_code=0.
- One record pushed, no dut_valid for 64 cycles → after the 64th edge: pending=0, mism_cnt=1, err_code=5.
- With RETIRE_CHECKER_XPROP_EN: exp_data=16'h12xx against dut_data 0x12FF → match. dut_flags=3'b0x0 → err_code=6. Without the macro, the first case gives err_code=2.
